// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port synchronous instruction memory between
// the core fetch stage (read-only) and the program loader / debug port
// (read/write). The loader can halt fetch, access memory, then release it.
//
// Optional feature macro: IMEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   f_req/f_addr        fetch request and byte address
//   f_gnt               fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata    fetch response, one cycle after accept
//   l_req/l_we/l_addr/l_wdata  loader request
//   l_gnt               loader accepted this cycle (combinational)
//   l_rvalid/l_rdata    loader read response, one cycle after accept
//   l_halt              loader requests fetch halt (level)
//   halt_ack            fetch halted and no fetch response pending
//   misalign            sticky flag: an accepted address had addr[1:0] != 0
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro interface
module imem_arbiter #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned Depth     = 512,
  parameter int unsigned StarveMax = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_req,
  input  logic [AddrWidth-1:0]     f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [31:0]              f_rdata,
  input  logic                     l_req,
  input  logic                     l_we,
  input  logic [AddrWidth-1:0]     l_addr,
  input  logic [31:0]              l_wdata,
  output logic                     l_gnt,
  output logic                     l_rvalid,
  output logic [31:0]              l_rdata,
  input  logic                     l_halt,
  output logic                     halt_ack,
  output logic                     misalign,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(Depth)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned IdxW = $clog2(Depth);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                 state_q, state_d;
  logic                   rd_valid_q;
  logic                   rd_owner_q;   // 1: loader owns the pending read
  logic                   misalign_q;
  logic                   force_fetch;
  logic                   f_acc, l_acc, f_pend;
  logic [AddrWidth-1:0]   acc_addr;

  // Starvation guard: after StarveMax loader wins over a waiting fetch,
  // fetch takes the next contended cycle.
`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(StarveMax + 1);
  logic [CntW-1:0] starve_q;

  assign force_fetch = (state_q == RUN) && f_req && (starve_q == CntW'(StarveMax));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (f_acc || !f_req) begin
      starve_q <= '0;
    end else if (l_acc && (state_q == RUN) && (starve_q != CntW'(StarveMax))) begin
      starve_q <= starve_q + CntW'(1);
    end
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = ^32'(StarveMax);
  assign force_fetch       = 1'b0;
`endif

  // Grants: loader priority, fetch only in RUN, nothing while in reset.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      l_gnt = l_req && !force_fetch;
      f_gnt = (state_q == RUN) && f_req && (!l_req || force_fetch);
    end
  end

  assign f_acc  = f_req && f_gnt;
  assign l_acc  = l_req && l_gnt;
  assign f_pend = rd_valid_q && !rd_owner_q;

  // Memory strobe; address and data forced to zero when idle.
  always_comb begin
    acc_addr  = '0;
    mem_en    = f_acc || l_acc;
    mem_we    = l_acc && l_we;
    mem_wdata = '0;
    if (l_acc) begin
      acc_addr  = l_addr;
      mem_wdata = l_wdata;
    end else if (f_acc) begin
      acc_addr  = f_addr;
    end
    // Truncation to the word index gives the modulo-Depth wrap.
    mem_addr = IdxW'(acc_addr >> 2);
  end

  // Next-state logic for the halt handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (l_halt) state_d = DRAIN;
      DRAIN:   begin
        if (!l_halt)     state_d = RUN;
        else if (!f_pend) state_d = HALTED;
      end
      HALTED:  if (!l_halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= f_acc || (l_acc && !l_we);
      rd_owner_q <= l_acc;
      if ((f_acc || l_acc) && (acc_addr[1:0] != 2'b00)) misalign_q <= 1'b1;
    end
  end

  // Response routing; a reset in the response cycle drops it.
  assign f_rvalid = rd_valid_q && !rd_owner_q && !rst;
  assign l_rvalid = rd_valid_q &&  rd_owner_q && !rst;
  assign f_rdata  = f_rvalid ? mem_rdata : 32'h0;
  assign l_rdata  = l_rvalid ? mem_rdata : 32'h0;
  assign halt_ack = (state_q == HALTED) && !rst;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural
// single-port synchronous memory (word k preloaded with k + 0x100).
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_we, l_halt;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, halt_ack, misalign;
  logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;

  logic [31:0] mem [512];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.AddrWidth(32), .Depth(512), .StarveMax(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_halt(l_halt), .halt_ack(halt_ack),
    .misalign(misalign), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and drive inputs; checks follow after #1.
  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic lh);
    @(negedge clk);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_halt = lh;
    #1;
  endtask

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 32'(k) + 32'h100;
    mem_rdata = '0;
    rst = 1'b1;
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_halt = 0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_outs", {f_gnt, l_gnt, f_rvalid, l_rvalid, halt_ack, misalign, mem_en, mem_we}, 32'h0);
    check("rst_data", f_rdata | l_rdata | mem_wdata | 32'(mem_addr), 32'h0);
    rst = 1'b0;

    // Fetch-only stream
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    check("fs0_gnt", {f_gnt, mem_en, mem_we}, 32'b110);
    check("fs0_addr", 32'(mem_addr), 32'h0);
    drive(1, 32'h4, 0, 0, 0, 0, 0);
    check("fs1_gnt", {f_gnt, f_rvalid}, 32'b11);
    check("fs1_data", f_rdata, 32'h100);
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    check("fs2_gnt", {f_gnt, f_rvalid}, 32'b11);
    check("fs2_data", f_rdata, 32'h101);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("fs3_valid", {f_gnt, f_rvalid, mem_en}, 32'b010);
    check("fs3_data", f_rdata, 32'h102);
    check("idle_addr", 32'(mem_addr) | mem_wdata, 32'h0);

    // Contention: loader wins
    drive(1, 32'h0, 1, 0, 32'h14, 0, 0);
    check("ct_gnt", {l_gnt, f_gnt}, 32'b10);
    check("ct_addr", 32'(mem_addr), 32'h5);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("ct_rvalid", {l_rvalid, f_rvalid}, 32'b10);
    check("ct_rdata", l_rdata, 32'h105);

    // Halt / program / readback
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    check("h0_fgnt", {f_gnt, halt_ack}, 32'b10);
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    check("h1_drain", {f_gnt, f_rvalid, halt_ack}, 32'b010);
    check("h1_data", f_rdata, 32'h103);
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    check("h2_drain", {f_gnt, f_rvalid, halt_ack}, 32'b000);
    drive(1, 32'hC, 1, 1, 32'h10, 32'hDEADBEEF, 1);
    check("h3_halted", {halt_ack, f_gnt, l_gnt, mem_we}, 32'b1011);
    check("h3_wr", mem_wdata, 32'hDEADBEEF);
    check("h3_addr", 32'(mem_addr), 32'h4);
    drive(1, 32'hC, 1, 0, 32'h10, 0, 1);
    check("h4_rd", {halt_ack, f_gnt, l_gnt, l_rvalid}, 32'b1010);
    drive(1, 32'hC, 0, 0, 0, 0, 0);
    check("h5_rv", {halt_ack, f_gnt, l_rvalid}, 32'b101);
    check("h5_data", l_rdata, 32'hDEADBEEF);
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    check("h6_resume", {halt_ack, f_gnt}, 32'b01);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("h7_data", {31'h0, f_rvalid}, 32'h1);
    check("h7_rdata", f_rdata, 32'hDEADBEEF);

    // Sustained contention: guard pattern or strict loader priority
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h0, 1, 0, 32'h8, 0, 0);
`ifdef IMEM_ARB_STARVE_GUARD_EN
      check("sv_gnt", {f_gnt, l_gnt}, (i % 5 == 4) ? 32'b10 : 32'b01);
`else
      check("sv_gnt", {f_gnt, l_gnt}, 32'b01);
`endif
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Misalign and wrap
    check("ma_clear", {31'h0, misalign}, 32'h0);
    drive(1, 32'h802, 0, 0, 0, 0, 0);
    check("ma_gnt", {f_gnt, mem_en}, 32'b11);
    check("ma_addr", 32'(mem_addr), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("ma_set", {misalign, f_rvalid}, 32'b11);
    check("ma_data", f_rdata, 32'h100);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("ma_sticky", {31'h0, misalign}, 32'h1);

    // Reset mid-read
    drive(0, 0, 1, 0, 32'h4, 0, 1);
    check("rr_gnt", {31'h0, l_gnt}, 32'h1);
    @(negedge clk);
    rst = 1'b1; l_req = 0; l_halt = 0;
    #1;
    check("rr_drop", {l_rvalid, f_rvalid, l_gnt, f_gnt, mem_en}, 32'h0);
    check("rr_rdata", l_rdata, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rr_outs", {f_gnt, l_gnt, f_rvalid, l_rvalid, halt_ack, misalign, mem_en, mem_we}, 32'h0);
    check("rr_data", f_rdata | l_rdata | mem_wdata | 32'(mem_addr), 32'h0);
    rst = 1'b0;
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    check("rr_run", {f_gnt, halt_ack, l_rvalid}, 32'b100);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rr_fdata", f_rdata, 32'h102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
